// File: rtl/ff_apb_gpio_pkg.sv
// ---------------------------------------------------------------------------
// ff_apb_gpio_pkg
//  Shared definitions for the APB GPIO peripheral.
//  - gpio_reg_e : register select, decoded from paddr[4:2]
//  - FF_GPIO_ID_VALUE : default constant returned by the ID register
//  - ff_gpio_byte_off : byte address of a register (for bus models/firmware)
// ---------------------------------------------------------------------------
package ff_apb_gpio_pkg;

  typedef enum logic [2:0] {
    REG_DOUT    = 3'd0,   // 0x00 RW  pin output values
    REG_OE      = 3'd1,   // 0x04 RW  pin output enables
    REG_DIN     = 3'd2,   // 0x08 RO  synchronized pin inputs
    REG_RISE_EN = 3'd3,   // 0x0C RW  rising-edge capture enables
    REG_FALL_EN = 3'd4,   // 0x10 RW  falling-edge capture enables
    REG_STAT    = 3'd5,   // 0x14 W1C latched edge flags
    REG_IRQ_EN  = 3'd6,   // 0x18 RW  interrupt enables per flag
    REG_ID      = 3'd7    // 0x1C RO  identification constant
  } gpio_reg_e;

  localparam logic [31:0] FF_GPIO_ID_VALUE = 32'h4646_0001;

  // Registers are word aligned: byte offset = index * 4.
  function automatic logic [7:0] ff_gpio_byte_off(gpio_reg_e r);
    return {3'b000, r, 2'b00};
  endfunction

endpackage

// File: rtl/ff_apb_gpio_sync2.sv
// ---------------------------------------------------------------------------
// ff_sync2
//  Two-flop synchronizer for asynchronous inputs, synchronous active-high
//  reset. Each bit is synchronized independently; multi-bit values are not
//  guaranteed coherent across bits.
//  Ports:
//    clk    in  1      clock
//    reset  in  1      synchronous reset, active high (clears both stages)
//    d      in  WIDTH  asynchronous input
//    q      out WIDTH  synchronized output (2 clk latency)
// ---------------------------------------------------------------------------
module ff_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/ff_apb_gpio.sv
// ---------------------------------------------------------------------------
// ff_apb_gpio
//  APB slave GPIO block. Software-controlled pin outputs/enables, pins
//  sampled through a 2-flop synchronizer, programmable rise/fall edge
//  capture into W1C status flags, and a registered level interrupt.
//  Zero-wait-state APB, no error response.
//  Ports:
//    clk, reset          clock; synchronous active-high reset
//    paddr               APB address (only [4:2] decoded)
//    psel/penable/pwrite APB control; write commits on psel&penable&pwrite
//    pwdata / prdata     APB data; prdata is 0 unless psel&~pwrite
//    gpio_i              asynchronous pin inputs
//    gpio_o / gpio_oe    pin output value / drive enable (1 = drive)
//    irq                 level interrupt, |(STAT & IRQ_EN) registered
// ---------------------------------------------------------------------------
module ff_apb_gpio
  import ff_apb_gpio_pkg::*;
#(
  parameter int          GPIO_WIDTH = 4,
  parameter int          ADDR_WIDTH = 20,
  parameter logic [31:0] ID_VALUE   = FF_GPIO_ID_VALUE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [31:0]           pwdata,
  output logic [31:0]           prdata,
  input  logic [GPIO_WIDTH-1:0] gpio_i,
  output logic [GPIO_WIDTH-1:0] gpio_o,
  output logic [GPIO_WIDTH-1:0] gpio_oe,
  output logic                  irq
);

  localparam int W = GPIO_WIDTH;

  // ---- bus decode ---------------------------------------------------------
  gpio_reg_e      sel;
  logic           wr_en;
  logic [W-1:0]   wdata;

  assign sel   = gpio_reg_e'(paddr[4:2]);
  assign wr_en = psel & penable & pwrite;
  assign wdata = pwdata[W-1:0];   // bits above the pin count are dropped

  // Address bits outside [4:2] and data bits above W carry no meaning here.
  logic unused_bus_bits;
  assign unused_bus_bits = ^{paddr, pwdata};

  // ---- register state -----------------------------------------------------
  logic [W-1:0] dout_q, oe_q, rise_en_q, fall_en_q, stat_q, irq_en_q;
  logic [W-1:0] din, prev_q;

  assign gpio_o  = dout_q;
  assign gpio_oe = oe_q;

  // ---- input path ---------------------------------------------------------
  ff_sync2 #(.WIDTH(W)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (gpio_i),
    .q     (din)
  );

  // Edge detect on the synchronized value against its one-cycle-old copy.
  logic [W-1:0] rise, fall;
  assign rise = din & ~prev_q;
  assign fall = ~din & prev_q;

  // ---- status update ------------------------------------------------------
  // Clear is applied first and new edges OR'd in afterwards, so an edge that
  // lands on the same edge as a W1C of that bit keeps the flag set and no
  // event is lost. Edges are gated by the enables at the time they occur,
  // so turning an enable on never reports history.
  logic [W-1:0] w1c_mask, stat_nxt;
  assign w1c_mask = (wr_en && sel == REG_STAT) ? wdata : '0;
  assign stat_nxt = (stat_q & ~w1c_mask) | (rise & rise_en_q) | (fall & fall_en_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q    <= '0;
      dout_q    <= '0;
      oe_q      <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      stat_q    <= '0;
      irq_en_q  <= '0;
      irq       <= 1'b0;
    end else begin
      prev_q <= din;
      stat_q <= stat_nxt;
      // Uses current (pre-update) flags: irq trails STAT/IRQ_EN by one edge.
      irq    <= |(stat_q & irq_en_q);
      if (wr_en) begin
        case (sel)
          REG_DOUT:    dout_q    <= wdata;
          REG_OE:      oe_q      <= wdata;
          REG_RISE_EN: rise_en_q <= wdata;
          REG_FALL_EN: fall_en_q <= wdata;
          REG_IRQ_EN:  irq_en_q  <= wdata;
          default: ;   // DIN/ID read-only, STAT handled by w1c_mask
        endcase
      end
    end
  end

  // ---- read mux -----------------------------------------------------------
  // Purely combinational from registered state; valid in setup and access
  // phase alike, zero whenever the slave is not being read.
  always_comb begin
    prdata = '0;
    if (psel && !pwrite) begin
      case (sel)
        REG_DOUT:    prdata[W-1:0] = dout_q;
        REG_OE:      prdata[W-1:0] = oe_q;
        REG_DIN:     prdata[W-1:0] = din;
        REG_RISE_EN: prdata[W-1:0] = rise_en_q;
        REG_FALL_EN: prdata[W-1:0] = fall_en_q;
        REG_STAT:    prdata[W-1:0] = stat_q;
        REG_IRQ_EN:  prdata[W-1:0] = irq_en_q;
        REG_ID:      prdata        = ID_VALUE;
        default:     prdata        = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ff_apb_gpio.sv
module tb_ff_apb_gpio;
  import ff_apb_gpio_pkg::*;

  localparam int GW = 4;
  localparam int AW = 20;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] paddr = '0;
  logic          psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0]   pwdata = '0;
  logic [31:0]   prdata;
  logic [GW-1:0] gpio_i = '0;
  logic [GW-1:0] gpio_o, gpio_oe;
  logic          irq;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ff_apb_gpio #(.GPIO_WIDTH(GW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .paddr(paddr), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .gpio_i(gpio_i),
    .gpio_o(gpio_o), .gpio_oe(gpio_oe), .irq(irq)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
    end
  endtask

  // ---- reference model ----------------------------------------------------
  // Register image plus a history of pin samples taken at each clk edge
  // (ph[0] newest). The visible DIN is the sample from one edge back, an
  // edge is reported two edges after the pin change is first sampled.
  logic [GW-1:0] m_dout, m_oe, m_re, m_fe, m_stat, m_ien;
  logic          m_irq;
  logic [GW-1:0] ph [3];
  bit            model_on = 0;
  logic          m_wr;
  logic [2:0]    m_off;

  assign m_wr  = psel & penable & pwrite;
  assign m_off = paddr[4:2];

  always @(posedge clk) begin
    if (reset) begin
      m_dout <= '0; m_oe <= '0; m_re <= '0; m_fe <= '0;
      m_stat <= '0; m_ien <= '0; m_irq <= 1'b0;
      ph[0] <= '0; ph[1] <= '0; ph[2] <= '0;
    end else begin
      ph[0] <= gpio_i; ph[1] <= ph[0]; ph[2] <= ph[1];
      m_irq <= (m_stat & m_ien) != '0;
      m_stat <= (m_stat & ~((m_wr && m_off == 3'd5) ? pwdata[GW-1:0] : '0))
              | (ph[1] & ~ph[2] & m_re) | (~ph[1] & ph[2] & m_fe);
      if (m_wr) begin
        case (m_off)
          3'd0: m_dout <= pwdata[GW-1:0];
          3'd1: m_oe   <= pwdata[GW-1:0];
          3'd3: m_re   <= pwdata[GW-1:0];
          3'd4: m_fe   <= pwdata[GW-1:0];
          3'd6: m_ien  <= pwdata[GW-1:0];
          default: ;
        endcase
      end
    end
  end

  function automatic logic [31:0] exp_rd(input logic [2:0] off);
    case (off)
      3'd0: return 32'(m_dout);
      3'd1: return 32'(m_oe);
      3'd2: return 32'(ph[1]);
      3'd3: return 32'(m_re);
      3'd4: return 32'(m_fe);
      3'd5: return 32'(m_stat);
      3'd6: return 32'(m_ien);
      default: return FF_GPIO_ID_VALUE;
    endcase
  endfunction

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_on) begin
      chk("gpio_o",  32'(gpio_o),  32'(m_dout));
      chk("gpio_oe", 32'(gpio_oe), 32'(m_oe));
      chk("irq",     32'(irq),     32'(m_irq));
      chk("prdata",  prdata, (psel && !pwrite) ? exp_rd(m_off) : 32'h0);
    end
  end

  // ---- bus helpers --------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_addr(input logic [2:0] r);
    paddr = AW'($urandom);
    paddr[4:2] = r;
  endtask

  task automatic apb_wr(input logic [2:0] r, input logic [31:0] d);
    step(); psel = 1; penable = 0; pwrite = 1; set_addr(r); pwdata = d;
    step(); penable = 1;
    step(); psel = 0; penable = 0; pwrite = 0;
  endtask

  task automatic apb_rd(input logic [2:0] r, output logic [31:0] d);
    step(); psel = 1; penable = 0; pwrite = 0; set_addr(r);
    step(); penable = 1; #1 d = prdata;
    step(); psel = 0; penable = 0;
  endtask

  logic [31:0] rd;

  initial begin
    // 1: reset state
    repeat (3) @(posedge clk);
    #2 reset = 0; model_on = 1;
    for (int r = 0; r < 8; r++) begin
      apb_rd(3'(r), rd);
      chk($sformatf("rst_rd%0d", r), rd, (r == 7) ? 32'h4646_0001 : 32'h0);
    end
    chk("rst_gpio_o", 32'(gpio_o), 32'h0);
    chk("rst_gpio_oe", 32'(gpio_oe), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);

    // 2: output registers, upper bits dropped
    apb_wr(3'd0, 32'hFFFF_FFFA);
    apb_wr(3'd1, 32'h0000_000F);
    chk("dout_pin", 32'(gpio_o), 32'hA);
    chk("oe_pin", 32'(gpio_oe), 32'hF);
    apb_rd(3'd0, rd); chk("dout_rd", rd, 32'hA);
    apb_wr(3'd7, 32'h0); apb_rd(3'd7, rd); chk("id_ro", rd, 32'h4646_0001);

    // 3: sync latency and rise capture
    apb_wr(3'd3, 32'h5);
    step(); gpio_i = 4'h5;                 // settled before edge N
    step();                                // after N
    psel = 1; pwrite = 0; set_addr(3'd2); #1 chk("din_N", prdata, 32'h0);
    step();                                // after N+1
    #1 chk("din_N1", prdata, 32'h5);
    set_addr(3'd5); #1 chk("stat_N1", prdata, 32'h0);
    step();                                // after N+2
    #1 chk("stat_N2", prdata, 32'h5);
    psel = 0;

    // 4: irq on/off
    apb_wr(3'd6, 32'h1);
    chk("irq_pre", 32'(irq), 32'h0);
    step(); chk("irq_on", 32'(irq), 32'h1);
    apb_wr(3'd5, 32'h5);
    chk("irq_lag", 32'(irq), 32'h1);
    step(); chk("irq_off", 32'(irq), 32'h0);
    apb_rd(3'd5, rd); chk("stat_clr", rd, 32'h0);

    // 5: rising edge lands on the W1C commit edge of the same bit
    step(); gpio_i = 4'h4;
    step(); gpio_i = 4'h5;                 // sampled at edge C
    step(); psel = 1; penable = 0; pwrite = 1; set_addr(3'd5); pwdata = 32'h1;
    step(); penable = 1;
    step(); psel = 0; penable = 0; pwrite = 0;   // C+2: set and clear
    apb_rd(3'd5, rd); chk("set_wins", rd, 32'h1);
    chk("irq_held", 32'(irq), 32'h1);

    // 6: fall capture, then reset during an IRQ_EN write
    apb_wr(3'd5, 32'hF);
    gpio_i = 4'hD; repeat (4) step();
    apb_wr(3'd4, 32'h8);
    gpio_i = 4'h5; repeat (4) step();
    apb_rd(3'd5, rd); chk("fall_cap", rd, 32'h8);
    step(); psel = 1; penable = 0; pwrite = 1; set_addr(3'd6); pwdata = 32'hF;
    step(); penable = 1; reset = 1;
    step(); psel = 0; penable = 0; pwrite = 0; reset = 0;
    for (int r = 0; r < 8; r++) begin
      apb_rd(3'(r), rd);
      chk($sformatf("rst2_rd%0d", r), rd,
          (r == 7) ? 32'h4646_0001 : (r == 2) ? 32'h5 : 32'h0);
    end
    chk("rst2_irq", 32'(irq), 32'h0);
    chk("rst2_oe", 32'(gpio_oe), 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step();
      reset   = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 3) == 0) gpio_i = GW'($urandom);
      psel    = 1'($urandom);
      penable = 1'($urandom);
      pwrite  = 1'($urandom);
      paddr   = AW'($urandom);
      pwdata  = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 15));
    end
    step(); reset = 0; psel = 0; penable = 0; pwrite = 0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
